// File: rtl/perf_counter_sched.sv
// perf_counter_sched: four event channels share one WIDTH-bit adder.
// Each channel buffers events in a saturating pending accumulator.
// A round-robin scheduler folds one channel's pending count into its
// counter per cycle. A flush handshake drains all pending counts and
// blocks new events while software samples the bank.
// Optional build macro PERF_CTR_LOST_EN: sticky per-channel lost-event flags.
// Without it, lost reads 4'b0000.
module perf_counter_sched #(
  parameter int WIDTH  = 32,
  parameter int INC_W  = 2,
  parameter int PEND_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*INC_W-1:0] ev_inc,
  input  logic               clr,
  input  logic               flush_req,
  output logic               flush_done,
  input  logic [1:0]         rd_sel,
  output logic [WIDTH-1:0]   rd_data,
  output logic               busy,
  output logic [3:0]         lost
);

  // One extra bit so that pend + inc never wraps before the saturation compare.
  localparam int SUM_W = ((PEND_W > INC_W) ? PEND_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   cnt      [4];
  logic [PEND_W-1:0]  pend     [4];
  logic [PEND_W-1:0]  pend_nxt [4];
  logic [SUM_W-1:0]   pend_sum [4];
  logic [INC_W-1:0]   inc_eff  [4];
  logic [1:0]         ptr;
  logic [1:0]         grant;
  logic               grant_vld;
  logic               any_pend;

  // Event gating: new events are accepted only while running.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      inc_eff[i] = (state == S_RUN) ? ev_inc[i*INC_W +: INC_W] : '0;
    end
  end

  // Round-robin grant: first non-empty channel after the last granted one.
  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant     = ptr;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_vld && (pend[ptr + 2'(k)] != '0)) begin
        grant_vld = 1'b1;
        grant     = ptr + 2'(k);
      end
    end
  end

  // Next pending value: the granted channel restarts from this cycle's
  // increment, every other channel accumulates; both saturate.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (grant_vld && (grant == 2'(i))) begin
        pend_sum[i] = SUM_W'(inc_eff[i]);
      end else begin
        pend_sum[i] = SUM_W'(pend[i]) + SUM_W'(inc_eff[i]);
      end
      if (pend_sum[i] > PEND_MAX) begin
        pend_nxt[i] = PEND_MAX[PEND_W-1:0];
      end else begin
        pend_nxt[i] = pend_sum[i][PEND_W-1:0];
      end
    end
  end

  // Any non-zero accumulator means counts are not yet committed.
  always_comb begin
    any_pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pend[i] != '0) any_pend = 1'b1;
    end
  end

  // Counter bank, pending accumulators and pointer; clr beats any update.
  // NOTE: the counter bank is plain flops with a defined reset value, so it is reset like any other state, not left to power-up contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i]  <= '0;
        pend[i] <= '0;
      end
      ptr <= 2'd3;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i]  <= '0;
        pend[i] <= '0;
      end
      ptr <= 2'd3;
    end else begin
      // NOTE: non-blocking assignments let the commit read the old pend while pend takes its new value in the same edge.
      for (int i = 0; i < 4; i++) begin
        pend[i] <= pend_nxt[i];
      end
      if (grant_vld) begin
        cnt[grant] <= cnt[grant] + WIDTH'(pend[grant]);
        ptr        <= grant;
      end
    end
  end

  // Flush FSM next state; clr does not steer the FSM.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN:   if (flush_req) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!flush_req)    state_nxt = S_RUN;
        else if (!any_pend) state_nxt = S_DONE;
      end
      S_DONE:  if (!flush_req) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // Flush FSM state register; flush_done is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state_nxt == S_DONE);
    end
  end

`ifdef PERF_CTR_LOST_EN
  logic [3:0] sat;
  logic [3:0] lost_q;

  // An event is lost whenever the unsaturated next pending value overflows.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sat[i] = (pend_sum[i] > PEND_MAX);
    end
  end

  // Sticky lost flags, cleared only by clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   lost_q <= '0;
    else if (clr) lost_q <= '0;
    else          lost_q <= lost_q | sat;
  end

  assign lost = lost_q;
`else
  assign lost = 4'b0000;
`endif

  assign rd_data = cnt[rd_sel];
  assign busy    = any_pend;

endmodule

// File: tb/tb_perf_counter_sched.sv
// Scoreboard bench for perf_counter_sched. The stimulus pushes hand-computed
// expectations into a queue. A negedge monitor pops them and compares each
// one against the DUT outputs. Instance a has WIDTH=8 so it can show
// counter wrap. Instance b has PEND_W=2 so it can show saturation and lost
// flags. The expected lost value for b follows PERF_CTR_LOST_EN.
module tb_perf_counter_sched;

  typedef enum {K_CNT, K_BUSY, K_DONE, K_LOST} kind_e;
  typedef struct {
    string name;
    kind_e kind;
    bit    inst_b;
    int    ch;
    int    exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ev_a = '0, ev_b = '0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic       flush_a = 1'b0, flush_b = 1'b0;
  logic [1:0] rd_sel_a = '0, rd_sel_b = '0;
  logic       done_a, done_b, busy_a, busy_b;
  logic [7:0] rd_a, rd_b;
  logic [3:0] lost_a, lost_b;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  perf_counter_sched #(.WIDTH(8), .INC_W(2), .PEND_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ev_inc(ev_a), .clr(clr_a), .flush_req(flush_a),
    .flush_done(done_a), .rd_sel(rd_sel_a), .rd_data(rd_a), .busy(busy_a), .lost(lost_a)
  );

  perf_counter_sched #(.WIDTH(8), .INC_W(2), .PEND_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ev_inc(ev_b), .clr(clr_b), .flush_req(flush_b),
    .flush_done(done_b), .rd_sel(rd_sel_b), .rd_data(rd_b), .busy(busy_b), .lost(lost_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_v(input string name, input kind_e k, input int ch, input int exp, input bit b = 1'b0);
    exp_t e;
    e.name = name; e.kind = k; e.inst_b = b; e.ch = ch; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect_cnts(input string tag, input int c0, input int c1, input int c2, input int c3,
                             input bit b = 1'b0);
    int c[4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) expect_v($sformatf("%s_cnt%0d", tag, i), K_CNT, i, c[i], b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for flush_done on instance a; the first edge samples flush_req.
  task automatic wait_done(input string name, input int bound);
    int n = 0;
    step();
    while (!done_a && n < 8) begin
      step();
      n++;
    end
    check({name, "_flush_lat"}, 32'(done_a && (n <= bound)), 32'd1);
  endtask

  // Monitor: compare every queued expectation against the state after the last edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_CNT: begin
          if (mon_e.inst_b) rd_sel_b = 2'(mon_e.ch);
          else              rd_sel_a = 2'(mon_e.ch);
          #1;
          check(mon_e.name, mon_e.inst_b ? 32'(rd_b) : 32'(rd_a), 32'(mon_e.exp));
        end
        K_BUSY: check(mon_e.name, mon_e.inst_b ? 32'(busy_b) : 32'(busy_a), 32'(mon_e.exp));
        K_DONE: check(mon_e.name, mon_e.inst_b ? 32'(done_b) : 32'(done_a), 32'(mon_e.exp));
        default: check(mon_e.name, mon_e.inst_b ? 32'(lost_b) : 32'(lost_a), 32'(mon_e.exp));
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lost_b_exp;
`ifdef PERF_CTR_LOST_EN
    lost_b_exp = 4'hF;
`else
    lost_b_exp = 0;
`endif
    // Reset values.
    step(); step();
    rst_n = 1'b1;
    expect_cnts("rst", 0, 0, 0, 0);
    expect_v("rst_busy", K_BUSY, 0, 0);
    expect_v("rst_done", K_DONE, 0, 0);
    expect_v("rst_lost", K_LOST, 0, 0);

    // Single event on channel 0: visible two edges after it is driven.
    step();
    ev_a = 8'h01;
    step();
    ev_a = 8'h00;
    expect_v("single_busy_hi", K_BUSY, 0, 1);
    expect_v("single_cnt0_pre", K_CNT, 0, 0);
    step();
    expect_v("single_busy_lo", K_BUSY, 0, 0);
    expect_cnts("single", 1, 0, 0, 0);

    // Contention: all channels inc=3 for 10 edges, grants 0,1,2,3,...
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    expect_cnts("clr1", 0, 0, 0, 0);
    ev_a = 8'hFF;
    step();
    step();
    expect_v("cont_e2_cnt0", K_CNT, 0, 3);
    expect_v("cont_e2_cnt1", K_CNT, 1, 0);
    step();
    expect_v("cont_e3_cnt1", K_CNT, 1, 6);
    expect_v("cont_e3_cnt2", K_CNT, 2, 0);
    repeat (7) step();
    ev_a = 8'h00;
    flush_a = 1'b1;
    wait_done("cont", 5);
    expect_cnts("cont", 30, 30, 30, 30);
    expect_v("cont_busy", K_BUSY, 0, 0);
    expect_v("cont_lost", K_LOST, 0, 0);
    flush_a = 1'b0;
    step();
    expect_v("cont_done_lo", K_DONE, 0, 0);

    // Wrap: channel 2 inc=3 for 100 edges in an 8-bit counter.
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    ev_a = 8'h30;
    repeat (100) step();
    ev_a = 8'h00;
    flush_a = 1'b1;
    wait_done("wrap", 5);
    expect_cnts("wrap", 0, 0, 44, 0);
    flush_a = 1'b0;
    step();

    // Flush blocks events; counting resumes the edge after release.
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    ev_a = 8'h04;
    repeat (5) step();
    flush_a = 1'b1;
    wait_done("blk", 5);
    expect_v("blk_cnt1_a", K_CNT, 1, 6);
    repeat (3) step();
    expect_v("blk_cnt1_b", K_CNT, 1, 6);
    expect_v("blk_done_hi", K_DONE, 0, 1);
    flush_a = 1'b0;
    step();
    expect_v("blk_done_lo", K_DONE, 0, 0);
    expect_v("blk_cnt1_m", K_CNT, 1, 6);
    step();
    expect_v("blk_cnt1_m1", K_CNT, 1, 6);
    expect_v("blk_busy_m1", K_BUSY, 0, 1);
    step();
    expect_v("blk_cnt1_m2", K_CNT, 1, 7);
    ev_a = 8'h00;

    // Clear while draining with pending counts.
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    ev_a = 8'hFF;
    repeat (3) step();
    ev_a = 8'h00;
    flush_a = 1'b1;
    step();
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    expect_cnts("drclr", 0, 0, 0, 0);
    expect_v("drclr_busy", K_BUSY, 0, 0);
    expect_v("drclr_done_lo", K_DONE, 0, 0);
    expect_v("drclr_lost", K_LOST, 0, 0);
    step();
    expect_v("drclr_done_hi", K_DONE, 0, 1);
    flush_a = 1'b0;
    step();

    // Narrow accumulators: all channels inc=3 for 8 edges saturate.
    ev_b = 8'hFF;
    repeat (8) step();
    ev_b = 8'h00;
    repeat (6) step();
    expect_cnts("sat", 9, 9, 9, 6, 1'b1);
    expect_v("sat_lost", K_LOST, 0, lost_b_exp, 1'b1);
    expect_v("sat_busy", K_BUSY, 0, 0, 1'b1);

    step();
    step();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
